// File: rtl/uop_cache_sdp.sv
// uop_cache_sdp: simple-dual-port micro-op store (one write port, one read port)
// with per-entry valid bits, write-first forwarding, a hit flag on every read,
// and a clear sequencer that zeroes the array after reset or on flush.
//
// Optional build macro: UOP_CACHE_OUTREG_EN adds an output register stage on
// rd_data/rd_hit/rd_valid, which makes the read latency 2 cycles instead of 1.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | sequencer zeroes one entry per cycle; writes refused; no hits
// ST_READY | normal operation; writes accepted unless flush is asserted
module uop_cache_sdp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_hit,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;

  logic                    clearing;
  logic                    wr_acc;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]        valid_q;

  logic [DATA_WIDTH-1:0]   ram_q;
  logic [DATA_WIDTH-1:0]   fwd_data_q;
  logic                    fwd_q;
  logic                    zero_q;
  logic                    hit1_q;
  logic                    valid1_q;
  logic [DATA_WIDTH-1:0]   data1;

  assign clearing = (state_q == ST_CLEAR);
  assign wr_ready = (state_q == ST_READY) && !flush;
  assign wr_acc   = wr_en && wr_ready;
  assign busy     = clearing;

  // The clear sequencer and the write port share the single RAM write port;
  // they never collide because writes are refused while clearing.
  assign mem_we    = !reset && (clearing || wr_acc);
  assign mem_waddr = clearing ? clr_cnt_q : wr_addr;
  assign mem_wdata = clearing ? '0 : wr_data;

  // State and clear-counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state logic: flush always restarts the full clear from entry 0.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (flush) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_READY;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        if (flush) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Data array write port (no reset so it maps onto block RAM).
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Valid bits follow the array: cleared by the sequencer, set by writes.
  always_ff @(posedge clk) begin
    if (mem_we) valid_q[mem_waddr] <= !clearing;
  end

  // Synchronous RAM read plus captured forwarding data; held when idle.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      ram_q      <= mem[rd_addr];
      fwd_data_q <= wr_data;
    end
  end

  // Read-cycle control: forwarding select, hit decision, valid, reset masking.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid1_q <= 1'b0;
      fwd_q    <= 1'b0;
      hit1_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      valid1_q <= rd_en;
      if (rd_en) begin
        zero_q <= 1'b0;
        fwd_q  <= wr_acc && (wr_addr == rd_addr);
        hit1_q <= (wr_acc && (wr_addr == rd_addr)) ||
                  (valid_q[rd_addr] && (state_q == ST_READY));
      end
    end
  end

  // zero_q masks the uninitialised RAM output register until the first read.
  assign data1 = zero_q ? '0 : (fwd_q ? fwd_data_q : ram_q);

`ifdef UOP_CACHE_OUTREG_EN
  logic [DATA_WIDTH-1:0] data2_q;
  logic                  hit2_q;
  logic                  valid2_q;

  // Output stage: loads only on a valid first-stage response, else holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      data2_q  <= '0;
      hit2_q   <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      valid2_q <= valid1_q;
      if (valid1_q) begin
        data2_q <= data1;
        hit2_q  <= hit1_q;
      end
    end
  end

  assign rd_data  = data2_q;
  assign rd_hit   = hit2_q;
  assign rd_valid = valid2_q;
`else
  assign rd_data  = data1;
  assign rd_hit   = hit1_q;
  assign rd_valid = valid1_q;
`endif

endmodule

// File: tb/tb_uop_cache_sdp.sv
// Directed self-checking bench for uop_cache_sdp (default 32x512 geometry).
module tb_uop_cache_sdp;

`ifdef UOP_CACHE_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, wr_en, rd_en;
  logic [8:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic        wr_ready, rd_valid, rd_hit, busy;
  logic [31:0] rd_data;

  int total  = 0;
  int passed = 0;

  uop_cache_sdp dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_hit(rd_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one read, then wait until its response is on the outputs.
  task automatic do_read(input logic [8:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    step();
    rd_en = 1'b0;
    repeat (LAT - 1) step();
  endtask

  // Count cycles with busy high, from now until it drops (bounded).
  task automatic count_busy(output int n, output bit wr_seen);
    n = 0;
    wr_seen = 0;
    while (busy && n < 2000) begin
      if (wr_ready) wr_seen = 1;
      n++;
      step();
    end
  endtask

  int n_busy;
  bit wr_seen;
  int errs, resp;

  initial begin
    reset = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;

    // Reset values.
    step();
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_hit", rd_hit, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_busy", busy, 1);
    step();
    reset = 1'b0;

    // Clear after reset lasts exactly DEPTH cycles.
    count_busy(n_busy, wr_seen);
    check("clear_len_reset", n_busy, 512);
    check("wr_ready_during_clear", wr_seen, 0);
    check("wr_ready_after_clear", wr_ready, 1);

    do_read(9'h1FF);
    check("cleared_valid", rd_valid, 1);
    check("cleared_hit", rd_hit, 0);
    check("cleared_data", rd_data, 0);

    // Write then read next cycle.
    wr_en = 1'b1; wr_addr = 9'd5; wr_data = 32'hDEADBEEF;
    step();
    wr_en = 1'b0;
    do_read(9'd5);
    check("wr_rd_valid", rd_valid, 1);
    check("wr_rd_hit", rd_hit, 1);
    check("wr_rd_data", rd_data, 32'hDEADBEEF);

    // Idle cycles: valid drops, data and hit hold.
    repeat (LAT) step();
    check("idle_valid", rd_valid, 0);
    check("idle_data_hold", rd_data, 32'hDEADBEEF);
    check("idle_hit_hold", rd_hit, 1);

    // Same-address collision: write-first forwarding.
    wr_en = 1'b1; wr_addr = 9'd7; wr_data = 32'h12345678;
    rd_en = 1'b1; rd_addr = 9'd7;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (LAT - 1) step();
    check("fwd_data", rd_data, 32'h12345678);
    check("fwd_hit", rd_hit, 1);

    // Different addresses in the same cycle are independent.
    wr_en = 1'b1; wr_addr = 9'd9; wr_data = 32'h99;
    rd_en = 1'b1; rd_addr = 9'd8;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (LAT - 1) step();
    check("indep_valid", rd_valid, 1);
    check("indep_hit", rd_hit, 0);
    check("indep_data", rd_data, 0);
    do_read(9'd9);
    check("indep_wr9_data", rd_data, 32'h99);

    // Flush together with a write: the write is dropped.
    flush = 1'b1; wr_en = 1'b1; wr_addr = 9'd3; wr_data = 32'hAA;
    #1;
    check("flush_wr_ready", wr_ready, 0);
    step();
    flush = 1'b0; wr_en = 1'b0;
    count_busy(n_busy, wr_seen);
    check("clear_len_flush", n_busy, 512);
    do_read(9'd3);
    check("flushed3_hit", rd_hit, 0);
    check("flushed3_data", rd_data, 0);
    do_read(9'd5);
    check("flushed5_hit", rd_hit, 0);
    check("flushed5_data", rd_data, 0);

    // Flush restart mid-clear at counter 100.
    wr_en = 1'b1; wr_addr = 9'd300; wr_data = 32'h55;
    step();
    wr_en = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    do_read(9'd300);                 // issued at counter 0, entry 300 not yet cleared
    check("clr_rd_valid", rd_valid, 1);
    check("clr_rd_hit", rd_hit, 0);
    check("clr_rd_data", rd_data, 32'h55);
    repeat (100 - LAT) step();       // counter now 100
    check("busy_mid_clear", busy, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    count_busy(n_busy, wr_seen);
    check("clear_len_restart", n_busy, 512);
    do_read(9'd300);
    check("restart300_hit", rd_hit, 0);
    check("restart300_data", rd_data, 0);

    // Back-to-back streaming: write n, read n-1, every cycle.
    errs = 0;
    resp = 0;
    for (int n = 0; n <= 511 + LAT; n++) begin
      wr_en = (n <= 511);
      wr_addr = 9'(n);
      wr_data = 32'(n * 3);
      rd_en = (n >= 1) && (n <= 511);
      rd_addr = 9'(n - 1);
      step();
      begin
        int r;
        r = n - (LAT - 1);
        if (r >= 1 && r <= 511) begin
          resp++;
          if (rd_valid !== 1'b1 || rd_hit !== 1'b1 || rd_data !== 32'((r - 1) * 3))
            errs++;
        end
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    check("stream_responses", resp, 511);
    check("stream_errors", errs, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
